// File: rtl/prog_rom.sv
// Sim-AC program/data ROM: 32 x 8-bit words with a fixed image.
// Read path is combinational by default; REG_OUT=1 adds an output register
// with asynchronous active-low clear for synchronous fetch timing.
module prog_rom #(
  parameter bit REG_OUT = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] addr_i,
  output logic [7:0] data_o
);

  logic [7:0] rom_data;

  // Full 5-bit decode of the stored image; unlisted words read as zero.
  always_comb begin
    rom_data = 8'h00;
    case (addr_i)
      5'h00:   rom_data = 8'h3E;
      5'h01:   rom_data = 8'h5F;
      5'h02:   rom_data = 8'h9D;
      5'h03:   rom_data = 8'hE0;
      5'h1E:   rom_data = 8'h05;
      5'h1F:   rom_data = 8'h03;
      default: rom_data = 8'h00;
    endcase
  end

  if (REG_OUT) begin : g_reg_out
    logic [7:0] data_q;

    // Output register; reset clears it immediately, independent of the clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q <= 8'h00;
      end else begin
        data_q <= rom_data;
      end
    end

    assign data_o = data_q;
  end else begin : g_comb_out
    // Clock and reset play no part in the combinational read path.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;

    assign data_o = rom_data;
  end

endmodule

// File: tb/tb_prog_rom.sv
// Directed bench for prog_rom: one combinational and one registered instance.
module tb_prog_rom;

  logic       clk;
  logic       rst0, rst1;
  logic [4:0] addr0, addr1;
  logic [7:0] data0, data1;

  int checks = 0;
  int errors = 0;

  prog_rom #(.REG_OUT(1'b0)) u_comb (
    .clk_i  (clk),
    .rst_ni (rst0),
    .addr_i (addr0),
    .data_o (data0)
  );

  prog_rom #(.REG_OUT(1'b1)) u_reg (
    .clk_i  (clk),
    .rst_ni (rst1),
    .addr_i (addr1),
    .data_o (data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  // Reference image, written out independently from the table above.
  function automatic logic [7:0] image(input int a);
    if (a == 0) return 8'h3E;
    if (a == 1) return 8'h5F;
    if (a == 2) return 8'h9D;
    if (a == 3) return 8'hE0;
    if (a == 30) return 8'h05;
    if (a == 31) return 8'h03;
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int nz;
    vecs[0] = '{"a00", 5'h00, 8'h3E};
    vecs[1] = '{"a01", 5'h01, 8'h5F};
    vecs[2] = '{"a02", 5'h02, 8'h9D};
    vecs[3] = '{"a03", 5'h03, 8'hE0};
    vecs[4] = '{"a1e", 5'h1E, 8'h05};
    vecs[5] = '{"a1f", 5'h1F, 8'h03};
    vecs[6] = '{"a10", 5'h10, 8'h00};

    rst0  = 1'b1;
    rst1  = 1'b0;
    addr0 = 5'h00;
    addr1 = 5'h00;

    // Registered output is cleared by reset before any clock edge.
    #1;
    check("reg_reset_no_edge", data1, 8'h00);
    check("comb_time0", data0, 8'h3E);
    @(posedge clk); #1;
    check("reg_reset_held_edge", data1, 8'h00);

    // Combinational table, 10 ns apart.
    for (int i = 0; i < 7; i++) begin
      addr0 = vecs[i].addr;
      #10;
      check(vecs[i].name, data0, vecs[i].exp);
    end

    // Full sweep against the reference image; exactly six nonzero words.
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      addr0 = 5'(i);
      #1;
      check($sformatf("sweep_%0d", i), data0, image(i));
      if (data0 != 8'h00) nz++;
    end
    check("sweep_nonzero_count", 8'(nz), 8'd6);

    // Reset pulse has no effect on the combinational path.
    addr0 = 5'h01;
    #1;
    rst0 = 1'b0;
    #1;
    check("comb_rst_low", data0, 8'h5F);
    #7;
    check("comb_rst_low_edge", data0, 8'h5F);
    rst0 = 1'b1;
    #1;
    check("comb_rst_release", data0, 8'h5F);

    // Registered: release away from an edge, data only after the first edge.
    @(negedge clk);
    addr1 = 5'h02;
    rst1  = 1'b1;
    #1;
    check("reg_before_edge", data1, 8'h00);
    @(posedge clk); #1;
    check("reg_first_edge", data1, 8'h9D);

    // Back-to-back reads, one cycle latency each.
    @(negedge clk); addr1 = 5'h00;
    #1;
    check("reg_latency_hold", data1, 8'h9D);
    @(posedge clk); #1;
    check("reg_b2b_0", data1, 8'h3E);
    @(negedge clk); addr1 = 5'h01;
    @(posedge clk); #1;
    check("reg_b2b_1", data1, 8'h5F);
    @(negedge clk); addr1 = 5'h03;
    @(posedge clk); #1;
    check("reg_b2b_3", data1, 8'hE0);

    // Mid-stream reset between edges clears at once and holds across an edge.
    #1;
    rst1 = 1'b0;
    #1;
    check("reg_midstream_clear", data1, 8'h00);
    @(posedge clk); #1;
    check("reg_midstream_held", data1, 8'h00);
    @(negedge clk);
    addr1 = 5'h1E;
    rst1  = 1'b1;
    #1;
    check("reg_release_no_edge", data1, 8'h00);
    @(posedge clk); #1;
    check("reg_resume", data1, 8'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
